decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered, valid/ready instruction decode stage.
// Output register plus one skid register; sticky halt and accepted-instruction counter.
// Optional build macro DECODE_ILLEGAL_EN: flag undefined opcodes / control words as illegal
// and halt on them; otherwise they decode as nop.
module decode_stage #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned IMM_W      = 12,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_pi,
    input  logic                  reset_pi,
    input  logic [4+IMM_W-1:0]    instr_pi,
    input  logic                  in_valid_pi,
    output logic                  in_ready_po,
    output logic                  out_valid_po,
    input  logic                  out_ready_pi,
    output logic [2:0]            alu_func_po,
    output logic [REG_ADDR_W-1:0] dest_reg_po,
    output logic [REG_ADDR_W-1:0] src1_reg_po,
    output logic [REG_ADDR_W-1:0] src2_reg_po,
    output logic [IMM_W-1:0]      immediate_po,
    output logic [18:0]           op_flags_po,
    output logic                  halted_po,
    output logic [CNT_W-1:0]      instr_count_po
);

    localparam int unsigned INSTR_W   = 4 + IMM_W;
    localparam int unsigned R         = REG_ADDR_W;
    localparam int unsigned NUM_FLAGS = 19;

    localparam int unsigned FL_ARITH2  = 0;
    localparam int unsigned FL_ARITH1  = 1;
    localparam int unsigned FL_MOVI_LO = 2;
    localparam int unsigned FL_MOVI_HI = 3;
    localparam int unsigned FL_ADDI    = 4;
    localparam int unsigned FL_SUBI    = 5;
    localparam int unsigned FL_LOAD    = 6;
    localparam int unsigned FL_STORE   = 7;
    localparam int unsigned FL_BEQ     = 8;
    localparam int unsigned FL_BGE     = 9;
    localparam int unsigned FL_BLE     = 10;
    localparam int unsigned FL_BC      = 11;
    localparam int unsigned FL_JUMP    = 12;
    localparam int unsigned FL_STC     = 13;
    localparam int unsigned FL_STB     = 14;
    localparam int unsigned FL_HALT    = 15;
    localparam int unsigned FL_RST     = 16;
    localparam int unsigned FL_NOP     = 17;
    localparam int unsigned FL_ILLEGAL = 18;

    // 0xA repeated across the immediate: every odd bit set.
    function automatic logic [IMM_W-1:0] rst_pattern();
        logic [IMM_W-1:0] p;
        p = '0;
        for (int i = 1; i < int'(IMM_W); i += 2) begin
            p[i] = 1'b1;
        end
        return p;
    endfunction

    localparam logic [IMM_W-1:0] CTL_STC  = IMM_W'(1);
    localparam logic [IMM_W-1:0] CTL_STB  = IMM_W'(2);
    localparam logic [IMM_W-1:0] CTL_HALT = {IMM_W{1'b1}};
    localparam logic [IMM_W-1:0] CTL_RST  = rst_pattern();

    typedef struct packed {
        logic [2:0]           alu;
        logic [R-1:0]         dest;
        logic [R-1:0]         src1;
        logic [R-1:0]         src2;
        logic [IMM_W-1:0]     imm;
        logic [NUM_FLAGS-1:0] flags;
    } bundle_t;

    logic [3:0]       opcode;
    logic [IMM_W-1:0] imm_f;
    bundle_t          dec;
    logic             halt_c;

    bundle_t          out_q, out_d;
    bundle_t          skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             halted_q, halted_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic             drain;

    assign opcode = instr_pi[INSTR_W-1 -: 4];
    assign imm_f  = instr_pi[IMM_W-1:0];

    // Decode the incoming word into fields and a one-hot class.
    always_comb begin
        dec       = '0;
        halt_c    = 1'b0;
        dec.alu   = imm_f[2:0];
        dec.dest  = imm_f[IMM_W-1 -: R];
        dec.src1  = imm_f[IMM_W-1-R -: R];
        dec.src2  = imm_f[IMM_W-1-2*R -: R];
        dec.imm   = imm_f;
        dec.flags[FL_ILLEGAL] = 1'b0;
        case (opcode)
            4'h0: dec.flags[FL_NOP]    = 1'b1;
            4'h1: dec.flags[FL_ARITH2] = 1'b1;
            4'h2: dec.flags[FL_ARITH1] = 1'b1;
            4'h3: begin
                if (imm_f[IMM_W-1-R]) dec.flags[FL_MOVI_HI] = 1'b1;
                else                  dec.flags[FL_MOVI_LO] = 1'b1;
            end
            4'h4: dec.flags[FL_ADDI]  = 1'b1;
            4'h5: dec.flags[FL_SUBI]  = 1'b1;
            4'h6: dec.flags[FL_LOAD]  = 1'b1;
            4'h7: dec.flags[FL_STORE] = 1'b1;
            4'h8, 4'h9, 4'hA, 4'hB: begin
                // Branches compare dest-field against src1-field registers.
                dec.src1 = imm_f[IMM_W-1 -: R];
                dec.src2 = imm_f[IMM_W-1-R -: R];
                case (opcode)
                    4'h8:    dec.flags[FL_BEQ] = 1'b1;
                    4'h9:    dec.flags[FL_BGE] = 1'b1;
                    4'hA:    dec.flags[FL_BLE] = 1'b1;
                    default: dec.flags[FL_BC]  = 1'b1;
                endcase
            end
            4'hC: dec.flags[FL_JUMP] = 1'b1;
            4'hF: begin
                if (imm_f == CTL_STC) begin
                    dec.flags[FL_STC] = 1'b1;
                end else if (imm_f == CTL_STB) begin
                    dec.flags[FL_STB] = 1'b1;
                end else if (imm_f == CTL_RST) begin
                    dec.flags[FL_RST] = 1'b1;
                end else if (imm_f == CTL_HALT) begin
                    dec.flags[FL_HALT] = 1'b1;
                    halt_c = 1'b1;
                end else begin
`ifdef DECODE_ILLEGAL_EN
                    dec.flags[FL_ILLEGAL] = 1'b1;
                    halt_c = 1'b1;
`else
                    dec.flags[FL_NOP] = 1'b1;
`endif
                end
            end
            default: begin
`ifdef DECODE_ILLEGAL_EN
                dec.flags[FL_ILLEGAL] = 1'b1;
                halt_c = 1'b1;
`else
                dec.flags[FL_NOP] = 1'b1;
`endif
            end
        endcase
    end

    assign accept = in_valid_pi && in_ready_q;
    assign drain  = out_valid_q && out_ready_pi;

    // Next state of the two-entry queue, halt latch, counter and registered ready.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        halted_d     = halted_q;
        count_d      = count_q;

        if (accept) begin
            count_d = count_q + CNT_W'(1);
            if (halt_c) halted_d = 1'b1;
        end

        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end

        in_ready_d = !skid_valid_d && !halted_d;
    end

    // State registers; reset discards any pending bundles.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            halted_q     <= halted_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready_po    = in_ready_q;
    assign out_valid_po   = out_valid_q;
    assign alu_func_po    = out_q.alu;
    assign dest_reg_po    = out_q.dest;
    assign src1_reg_po    = out_q.src1;
    assign src2_reg_po    = out_q.src2;
    assign immediate_po   = out_q.imm;
    assign op_flags_po    = out_q.flags;
    assign halted_po      = halted_q;
    assign instr_count_po = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: vector table + scoreboard queue, plus hand sequences
// for backpressure, halt, illegal handling (DECODE_ILLEGAL_EN aware) and async reset.
module tb_decode_stage;

    localparam int F_ARITH2 = 0, F_ARITH1 = 1, F_MOVI_LO = 2, F_MOVI_HI = 3;
    localparam int F_ADDI = 4, F_SUBI = 5, F_LOAD = 6, F_STORE = 7;
    localparam int F_BEQ = 8, F_BGE = 9, F_BLE = 10, F_BC = 11, F_JUMP = 12;
    localparam int F_STC = 13, F_STB = 14, F_HALT = 15, F_RST = 16, F_NOP = 17;
`ifdef DECODE_ILLEGAL_EN
    localparam int F_BAD = 18;
`else
    localparam int F_BAD = 17;
`endif

    logic        clk_pi = 1'b0;
    logic        reset_pi;
    logic [15:0] instr_pi;
    logic        in_valid_pi;
    logic        in_ready_po;
    logic        out_valid_po;
    logic        out_ready_pi;
    logic [2:0]  alu_func_po;
    logic [2:0]  dest_reg_po, src1_reg_po, src2_reg_po;
    logic [11:0] immediate_po;
    logic [18:0] op_flags_po;
    logic        halted_po;
    logic [15:0] instr_count_po;

    decode_stage dut (
        .clk_pi        (clk_pi),
        .reset_pi      (reset_pi),
        .instr_pi      (instr_pi),
        .in_valid_pi   (in_valid_pi),
        .in_ready_po   (in_ready_po),
        .out_valid_po  (out_valid_po),
        .out_ready_pi  (out_ready_pi),
        .alu_func_po   (alu_func_po),
        .dest_reg_po   (dest_reg_po),
        .src1_reg_po   (src1_reg_po),
        .src2_reg_po   (src2_reg_po),
        .immediate_po  (immediate_po),
        .op_flags_po   (op_flags_po),
        .halted_po     (halted_po),
        .instr_count_po(instr_count_po)
    );

    always #5 clk_pi = ~clk_pi;

    typedef struct {
        logic [15:0] instr;
        int          flag;
        logic [2:0]  alu;
        logic [2:0]  dest;
        logic [2:0]  src1;
        logic [2:0]  src2;
    } vec_t;

    vec_t        vecs [21];
    logic [42:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cur_idx = 0;
    int          n_acc = 0;
    logic        acc_flag = 1'b0;
    logic        rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [42:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [42:0] exp_bundle(input int i);
        logic [18:0] f;
        logic [15:0] w;
        f = 19'(1) << vecs[i].flag;
        w = vecs[i].instr;
        return {vecs[i].alu, vecs[i].dest, vecs[i].src1, vecs[i].src2, w[11:0], f};
    endfunction

    function automatic logic [42:0] act_bundle();
        return {alu_func_po, dest_reg_po, src1_reg_po, src2_reg_po, immediate_po, op_flags_po};
    endfunction

    // Scoreboard step, called once per cycle at the falling edge.
    task automatic monitor();
        logic [42:0] act;
        logic [42:0] e;
        act = act_bundle();
        if (reset_pi) begin
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid_po), 64'(1));
            chk("hold_bundle", 64'(act), 64'(held));
        end
        if (out_valid_po) chk("one_hot", 64'($countones(op_flags_po)), 64'(1));
        if (out_valid_po && out_ready_pi) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got %0h expected none", act);
            end else begin
                e = exp_q.pop_front();
                chk("bundle", 64'(act), 64'(e));
            end
        end
        stall_prev = out_valid_po && !out_ready_pi;
        held = act;
        if (in_valid_pi && in_ready_po) begin
            exp_q.push_back(exp_bundle(cur_idx));
            n_acc++;
        end
    endtask

    task automatic tick();
        @(negedge clk_pi);
        monitor();
        acc_flag = in_valid_pi && in_ready_po;
        @(posedge clk_pi);
        #1;
        if (rand_ready) out_ready_pi = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int idx);
        logic ok;
        ok = 1'b0;
        cur_idx = idx;
        instr_pi = vecs[idx].instr;
        in_valid_pi = 1'b1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (acc_flag) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid_pi = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", vecs[idx].instr);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        reset_pi = 1'b1;
        tick();
        tick();
        reset_pi = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        n_acc = 0;
        chk("ready_before_edge", 64'(in_ready_po), 64'(0));
        tick();
        chk("ready_after_reset", 64'(in_ready_po), 64'(1));
    endtask

    initial begin
        int k;
        int acc_n;
        vecs[0]  = '{16'h1A4B, F_ARITH2,  3'd3, 3'd5, 3'd1, 3'd1};
        vecs[1]  = '{16'h3100, F_MOVI_HI, 3'd0, 3'd0, 3'd4, 3'd0};
        vecs[2]  = '{16'h8A40, F_BEQ,     3'd0, 3'd5, 3'd5, 3'd1};
        vecs[3]  = '{16'h2123, F_ARITH1,  3'd3, 3'd0, 3'd4, 3'd4};
        vecs[4]  = '{16'h3000, F_MOVI_LO, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[5]  = '{16'h4E52, F_ADDI,    3'd2, 3'd7, 3'd1, 3'd2};
        vecs[6]  = '{16'h5FFF, F_SUBI,    3'd7, 3'd7, 3'd7, 3'd7};
        vecs[7]  = '{16'h6248, F_LOAD,    3'd0, 3'd1, 3'd1, 3'd1};
        vecs[8]  = '{16'h7C87, F_STORE,   3'd7, 3'd6, 3'd2, 3'd0};
        vecs[9]  = '{16'h9640, F_BGE,     3'd0, 3'd3, 3'd3, 3'd1};
        vecs[10] = '{16'hA201, F_BLE,     3'd1, 3'd1, 3'd1, 3'd0};
        vecs[11] = '{16'hB000, F_BC,      3'd0, 3'd0, 3'd0, 3'd0};
        vecs[12] = '{16'hC123, F_JUMP,    3'd3, 3'd0, 3'd4, 3'd4};
        vecs[13] = '{16'h0000, F_NOP,     3'd0, 3'd0, 3'd0, 3'd0};
        vecs[14] = '{16'hF001, F_STC,     3'd1, 3'd0, 3'd0, 3'd0};
        vecs[15] = '{16'hF002, F_STB,     3'd2, 3'd0, 3'd0, 3'd0};
        vecs[16] = '{16'hFAAA, F_RST,     3'd2, 3'd5, 3'd2, 3'd5};
        vecs[17] = '{16'hD000, F_BAD,     3'd0, 3'd0, 3'd0, 3'd0};
        vecs[18] = '{16'hE123, F_BAD,     3'd3, 3'd0, 3'd4, 3'd4};
        vecs[19] = '{16'hF003, F_BAD,     3'd3, 3'd0, 3'd0, 3'd0};
        vecs[20] = '{16'hFFFF, F_HALT,    3'd7, 3'd7, 3'd7, 3'd7};

        reset_pi     = 1'b0;
        instr_pi     = '0;
        in_valid_pi  = 1'b0;
        out_ready_pi = 1'b1;
        #1;
        reset_pi = 1'b1;
        #1;
        chk("reset_state", 64'({out_valid_po, in_ready_po, halted_po, instr_count_po, act_bundle()}), 64'(0));
        @(posedge clk_pi);
        #1;
        do_reset();

        // Three back-to-back instructions, one bundle per cycle.
        send(0);
        chk("latency_1", 64'(out_valid_po), 64'(1));
        send(1);
        send(2);
        tick();
        chk("stream_idle", 64'(out_valid_po), 64'(0));
        chk("stream_count", 64'(instr_count_po), 64'(3));

        // Backpressure: two accepted, then ready drops.
        out_ready_pi = 1'b0;
        in_valid_pi = 1'b1;
        k = 3;
        acc_n = 0;
        for (int c = 0; c < 3; c++) begin
            cur_idx = k;
            instr_pi = vecs[k].instr;
            tick();
            if (acc_flag) begin
                k++;
                acc_n++;
            end
        end
        chk("bp_accepted", 64'(acc_n), 64'(2));
        chk("bp_ready_low", 64'(in_ready_po), 64'(0));
        chk("bp_out_valid", 64'(out_valid_po), 64'(1));
        out_ready_pi = 1'b1;
        send(5);
        drain();

        // Random downstream stalls over the remaining legal opcodes and control words.
        rand_ready = 1'b1;
        for (int i = 6; i <= 16; i++) send(i);
        rand_ready = 1'b0;
        out_ready_pi = 1'b1;
        drain();
        tick();
        chk("ctl_halted", 64'(halted_po), 64'(0));
        chk("ctl_ready", 64'(in_ready_po), 64'(1));
        chk("ctl_count", 64'(instr_count_po), 64'(n_acc));

        // Undefined opcode.
        send(17);
        drain();
        tick();
`ifdef DECODE_ILLEGAL_EN
        chk("illegal_halted", 64'(halted_po), 64'(1));
        chk("illegal_ready", 64'(in_ready_po), 64'(0));
`else
        chk("bad_halted", 64'(halted_po), 64'(0));
        send(18);
        send(19);
        drain();
        tick();
        chk("bad_halted2", 64'(halted_po), 64'(0));
        chk("bad_ready", 64'(in_ready_po), 64'(1));
`endif
        do_reset();
        chk("count_after_reset", 64'(instr_count_po), 64'(0));

        // Halt: bundle delivered, block stops accepting.
        send(20);
        chk("halt_rise", 64'(halted_po), 64'(1));
        cur_idx = 0;
        instr_pi = vecs[0].instr;
        in_valid_pi = 1'b1;
        tick();
        chk("halt_ready", 64'(in_ready_po), 64'(0));
        tick();
        tick();
        chk("halt_count", 64'(instr_count_po), 64'(1));
        chk("halt_delivered", 64'(exp_q.size()), 64'(0));
        chk("halt_sticky", 64'(halted_po), 64'(1));
        in_valid_pi = 1'b0;
        do_reset();

        // Asynchronous reset with the skid register full.
        out_ready_pi = 1'b0;
        send(0);
        send(1);
        chk("skid_full_ready", 64'(in_ready_po), 64'(0));
        @(negedge clk_pi);
        #2;
        reset_pi = 1'b1;
        #1;
        chk("async_reset", 64'({out_valid_po, in_ready_po, halted_po, instr_count_po, act_bundle()}), 64'(0));
        exp_q.delete();
        stall_prev = 1'b0;
        n_acc = 0;
        @(posedge clk_pi);
        #1;
        reset_pi = 1'b0;
        out_ready_pi = 1'b1;
        tick();
        chk("post_reset_ready", 64'(in_ready_po), 64'(1));
        chk("post_reset_valid", 64'(out_valid_po), 64'(0));
        chk("post_reset_count", 64'(instr_count_po), 64'(0));
        send(2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
